// File: rtl/mux_seq_ctrl.sv
// mux_seq_ctrl -- per-line demux phase sequencer.
//
// On each accepted line_start the panel is stepped through 1..3 demux
// phases. Each phase drives its select code for t_on cycles; phases are
// separated (and the line is framed) by t_gap cycles of the idle code.
// The {da,db} code feeds the existing registered mux decoder, so panel
// select lags {da,db} by one cycle.
//
// Phase codes {da,db}: phase0=00, phase1=01, phase2=10, idle=11.
//
// Optional build macro: MUX_SEQ_ALT_EN
//   When defined, a line-parity bit alternates the phase order per line
//   (even lines forward, odd lines reverse). When undefined the order is
//   always forward and no parity register exists.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   mux_en     in   sequencer enable; low aborts and forces idle
//   line_start in   single-cycle pulse starting one line sequence
//   nphase     in   phases per line (1..3; 0 runs 3)
//   t_on       in   phase on-time in cycles (0 treated as 1)
//   t_gap      in   non-overlap gap in cycles (0 = no gap states)
//   da, db     out  registered select code to the decoder
//   mux_vld    out  high while a phase code (not idle) is driven
//   busy       out  sequence in progress
//   line_done  out  single-cycle pulse on the final cycle of a sequence
//   overrun    out  single-cycle pulse after line_start arrives while busy

module mux_seq_ctrl #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mux_en,
  input  logic             line_start,
  input  logic [1:0]       nphase,
  input  logic [CNT_W-1:0] t_on,
  input  logic [CNT_W-1:0] t_gap,
  output logic             da,
  output logic             db,
  output logic             mux_vld,
  output logic             busy,
  output logic             line_done,
  output logic             overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_ON,
    S_GAP,
    S_TAIL,
    S_DONE
  } state_t;

  localparam logic [1:0]       CODE_IDLE = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // remaining cycles in state, minus one
  logic [1:0]       idx_q, idx_d;     // step number within the line
  logic [1:0]       nph_q, nph_d;     // latched effective phase count (1..3)
  logic [CNT_W-1:0] ton_q, ton_d;     // latched effective on-time (>=1)
  logic [CNT_W-1:0] tgap_q, tgap_d;   // latched gap time
  logic             rev_q, rev_d;     // latched reverse-order flag for this line

  logic             start;
  logic             par_src;
  logic [1:0]       nph_in;
  logic [CNT_W-1:0] ton_in;
  logic [1:0]       phase_d;
  logic [1:0]       code_d;

  assign start  = (state_q == S_IDLE) && mux_en && line_start;
  assign nph_in = (nphase == 2'd0) ? 2'd3 : nphase;
  assign ton_in = (t_on == '0) ? CNT_ONE : t_on;

`ifdef MUX_SEQ_ALT_EN
  // Parity of the line about to start; it toggles only after that line has
  // captured it, so the first line after reset runs forward.
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (start) begin
      par_q <= ~par_q;
    end
  end

  assign par_src = par_q;
`else
  assign par_src = 1'b0;
`endif

  // Next-state logic. Every counter load is "duration - 1" so a latched
  // all-ones value still yields 2^CNT_W-1 cycles without wrapping.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    nph_d   = nph_q;
    ton_d   = ton_q;
    tgap_d  = tgap_q;
    rev_d   = rev_q;

    if (!mux_en) begin
      // Abort wins over everything: straight back to idle, no line_done.
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (line_start) begin
            nph_d  = nph_in;
            ton_d  = ton_in;
            tgap_d = t_gap;
            rev_d  = par_src;
            idx_d  = 2'd0;
            if (t_gap != '0) begin
              state_d = S_LEAD;
              cnt_d   = t_gap - CNT_ONE;
            end else begin
              state_d = S_ON;
              cnt_d   = ton_in - CNT_ONE;
            end
          end
        end

        S_LEAD: begin
          if (cnt_q == '0) begin
            state_d = S_ON;
            cnt_d   = ton_q - CNT_ONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end

        S_ON: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end else if (idx_q != (nph_q - 2'd1)) begin
            // More phases remain: step the index now; the gap shows idle
            // regardless of the index.
            idx_d = idx_q + 2'd1;
            if (tgap_q != '0) begin
              state_d = S_GAP;
              cnt_d   = tgap_q - CNT_ONE;
            end else begin
              state_d = S_ON;
              cnt_d   = ton_q - CNT_ONE;
            end
          end else if (tgap_q != '0) begin
            state_d = S_TAIL;
            cnt_d   = tgap_q - CNT_ONE;
          end else begin
            state_d = S_DONE;
          end
        end

        S_GAP: begin
          if (cnt_q == '0) begin
            state_d = S_ON;
            cnt_d   = ton_q - CNT_ONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end

        S_TAIL: begin
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end

        S_DONE: begin
          state_d = S_IDLE;
          idx_d   = 2'd0;
        end

        default: begin
          state_d = S_IDLE;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and then registered, so they
  // line up with the state they describe without an extra cycle of lag.
  always_comb begin
    phase_d = rev_d ? (nph_d - 2'd1 - idx_d) : idx_d;
    code_d  = (state_d == S_ON) ? phase_d : CODE_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      nph_q     <= 2'd3;
      ton_q     <= CNT_ONE;
      tgap_q    <= '0;
      rev_q     <= 1'b0;
      da        <= 1'b1;
      db        <= 1'b1;
      mux_vld   <= 1'b0;
      busy      <= 1'b0;
      line_done <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its neighbours.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      nph_q     <= nph_d;
      ton_q     <= ton_d;
      tgap_q    <= tgap_d;
      rev_q     <= rev_d;
      {da, db}  <= code_d;
      mux_vld   <= (state_d == S_ON);
      busy      <= (state_d != S_IDLE);
      line_done <= (state_d == S_DONE);
      // A start request that is not accepted because a line (including its
      // DONE cycle) is in flight; requests while disabled are silently dropped.
      overrun   <= line_start && mux_en && (state_q != S_IDLE);
    end
  end

endmodule

// File: tb/tb_mux_seq_ctrl.sv
// tb_mux_seq_ctrl -- directed self-checking bench for mux_seq_ctrl.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge, half a cycle away from the active rising edge. Expected code
// sequences come from a small reference model of the line timing; line
// lengths are hand-computed constants.

module tb_mux_seq_ctrl;

  localparam int CNT_W = 12;

`ifdef MUX_SEQ_ALT_EN
  localparam bit ALT = 1'b1;
`else
  localparam bit ALT = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             mux_en;
  logic             line_start;
  logic [1:0]       nphase;
  logic [CNT_W-1:0] t_on;
  logic [CNT_W-1:0] t_gap;
  logic             da;
  logic             db;
  logic             mux_vld;
  logic             busy;
  logic             line_done;
  logic             overrun;

  int n_vec  = 0;
  int n_miss = 0;
  bit par    = 1'b0;  // bench copy of line parity

  mux_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mux_en     (mux_en),
    .line_start (line_start),
    .nphase     (nphase),
    .t_on       (t_on),
    .t_gap      (t_gap),
    .da         (da),
    .db         (db),
    .mux_vld    (mux_vld),
    .busy       (busy),
    .line_done  (line_done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: per-cycle {da,db} from first busy cycle through DONE.
  task automatic build_exp(input int nph, input int ton, input int tgap, input bit rev,
                           output logic [1:0] q[$]);
    int ne, te, p;
    q.delete();
    ne = (nph == 0) ? 3 : nph;
    te = (ton == 0) ? 1 : ton;
    for (int i = 0; i < tgap; i++) q.push_back(2'b11);
    for (int k = 0; k < ne; k++) begin
      p = rev ? (ne - 1 - k) : k;
      for (int i = 0; i < te; i++) q.push_back(2'(p));
      for (int i = 0; i < tgap; i++) q.push_back(2'b11);
    end
    q.push_back(2'b11);  // DONE cycle
  endtask

  // Drive one start pulse; returns at the falling edge of busy cycle 1.
  task automatic pulse_start(input int nph, input int ton, input int tgap);
    nphase     = 2'(nph);
    t_on       = CNT_W'(ton);
    t_gap      = CNT_W'(tgap);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  // Run one full line and compare it against the model. os1/os2 (1-based
  // busy cycle, 0 = unused) inject extra line_start pulses that must only
  // raise overrun on the following cycle.
  task automatic run_check(input string tag, input int nph, input int ton, input int tgap,
                           input int len, input int os1, input int os2);
    logic [1:0] q[$];
    int busy_cnt, done_at, vld_bad, c;
    bit exp_ovr;
    busy_cnt = 0;
    done_at  = 0;
    vld_bad  = 0;
    build_exp(nph, ton, tgap, ALT && par, q);
    pulse_start(nph, ton, tgap);
    par = ~par;
    // Mid-line input changes must have no effect.
    nphase = 2'd1;
    t_on   = CNT_W'(9);
    t_gap  = CNT_W'(5);
    for (int i = 0; i < q.size(); i++) begin
      c = i + 1;
      check($sformatf("%s code[%0d]", tag, c), 32'({da, db}), 32'(q[i]));
      exp_ovr = (os1 > 0 && c - 1 == os1) || (os2 > 0 && c - 1 == os2);
      check($sformatf("%s overrun[%0d]", tag, c), 32'(overrun), 32'(exp_ovr));
      if (busy) busy_cnt++;
      if (line_done && done_at == 0) done_at = c;
      if (mux_vld != (q[i] != 2'b11)) vld_bad++;
      line_start = (c == os1) || (c == os2);
      @(negedge clk);
    end
    line_start = 1'b0;
    c = q.size() + 1;
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(len));
    check({tag, " done_cycle"}, 32'(done_at), 32'(len));
    check({tag, " vld_errors"}, 32'(vld_bad), 32'd0);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    check({tag, " code_after"}, 32'({da, db}), 32'h3);
    exp_ovr = (os1 == len) || (os2 == len);
    check({tag, " overrun_after"}, 32'(overrun), 32'(exp_ovr));
    @(negedge clk);
    check({tag, " no_restart"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt_done, cnt_busy;
    rst_n      = 1'b0;
    mux_en     = 1'b0;
    line_start = 1'b0;
    nphase     = 2'd0;
    t_on       = '0;
    t_gap      = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst code", 32'({da, db}), 32'h3);
    check("rst busy", 32'(busy), 32'd0);
    check("rst vld", 32'(mux_vld), 32'd0);
    check("rst done", 32'(line_done), 32'd0);
    check("rst overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Disabled: line_start ignored, no overrun
    pulse_start(3, 4, 2);
    check("dis busy", 32'(busy), 32'd0);
    check("dis overrun", 32'(overrun), 32'd0);
    mux_en = 1'b1;
    repeat (3) @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);
    check("idle code", 32'({da, db}), 32'h3);

    // Nominal: 3*4 + 4*2 + 1 = 21
    run_check("nominal", 3, 4, 2, 21, 0, 0);
    // Zero gap: 2*3 + 1 = 7
    run_check("zero_gap", 2, 3, 0, 7, 0, 0);
    // t_on=0 treated as 1: 2*1 + 1 = 3
    run_check("ton_zero", 2, 0, 0, 3, 0, 0);
    // nphase=0 runs 3 phases: 3*1 + 4*1 + 1 = 8
    run_check("nph_zero", 0, 1, 1, 8, 0, 0);
    // Single phase with gaps: 1*2 + 2*3 + 1 = 9
    run_check("nph_one", 1, 2, 3, 9, 0, 0);
    // Overrun at busy cycle 5 and on the DONE cycle (21)
    run_check("overrun", 3, 4, 2, 21, 5, 21);

    // Abort during phase1 ON (cycles 9..12 of a 3/4/2 line)
    pulse_start(3, 4, 2);
    par = ~par;
    repeat (9) @(negedge clk);
    check("abort ph1 code", 32'({da, db}), 32'h1);
    mux_en = 1'b0;
    @(negedge clk);
    check("abort code", 32'({da, db}), 32'h3);
    check("abort busy", 32'(busy), 32'd0);
    check("abort vld", 32'(mux_vld), 32'd0);
    cnt_done = 0;
    cnt_busy = 0;
    for (int i = 0; i < 20; i++) begin
      if (line_done) cnt_done++;
      if (busy) cnt_busy++;
      @(negedge clk);
    end
    check("abort no_done", 32'(cnt_done), 32'd0);
    check("abort stays_idle", 32'(cnt_busy), 32'd0);
    mux_en = 1'b1;
    // Restart with new t_on: 3*2 + 4*1 + 1 = 11
    run_check("restart", 3, 2, 1, 11, 0, 0);

    // Asynchronous reset mid-sequence
    pulse_start(3, 4, 2);
    par = ~par;
    repeat (3) @(negedge clk);
    check("mid busy", 32'(busy), 32'd1);
    check("mid vld", 32'(mux_vld), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst code", 32'({da, db}), 32'h3);
    check("arst busy", 32'(busy), 32'd0);
    check("arst vld", 32'(mux_vld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    par   = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst busy", 32'(busy), 32'd0);

    // Two consecutive lines after reset: forward, then reverse when ALT.
    // 3*1 + 4*1 + 1 = 8
    run_check("line_a", 3, 1, 1, 8, 0, 0);
    run_check("line_b", 3, 1, 1, 8, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Watchdog: the directed run is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
